// File: rtl/gesture_msg_sequencer.sv
// rtl/gesture_msg_sequencer.sv - gesture qualifier, message queue and paced valid/ready sequencer
// Optional emergency pre-emption of code 4'hD is compiled in with `define EMERG_PREEMPT_EN.
module gesture_msg_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  gesture_in,
  input  logic                        msg_ready,
  output logic                        msg_valid,
  output logic [3:0]                  msg_code,
  output logic                        accept_pulse,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_cnt,
  output logic                        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_e;

  logic [3:0]    sample_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    last_q, last_d;
  logic          accept, accept_q;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, wr_addr;
  logic [LW-1:0] level_q, level_d, lost;
  logic [7:0]    drop_q, drop_d;
  logic [8:0]    drop_sum;
  logic          wr_en;

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pop, flush, preempt;
  logic [3:0]    head;

  // Run-length counter saturates at HOLD_CYCLES; last_q blocks re-accepting a held gesture.
  always_comb begin
    cnt_d = CW'(1);
    if (gesture_in == sample_q)
      cnt_d = (cnt_q == CW'(HOLD_CYCLES)) ? cnt_q : cnt_q + CW'(1);
    accept = (cnt_d == CW'(HOLD_CYCLES)) && (gesture_in != 4'h0) && (gesture_in != last_q);
    last_d = last_q;
    if (gesture_in == 4'h0)
      last_d = 4'h0;
    else if (accept)
      last_d = gesture_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= 4'h0;
      cnt_q    <= '0;
      last_q   <= 4'h0;
      accept_q <= 1'b0;
    end else begin
      sample_q <= gesture_in;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      accept_q <= accept;
    end
  end

`ifdef EMERG_PREEMPT_EN
  logic emerg_q;

  assign flush   = accept && (gesture_in == 4'hD);
  assign preempt = emerg_q;

  // Pending until the emergency entry (always at head after a flush) is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        emerg_q <= 1'b0;
    else if (flush) emerg_q <= 1'b1;
    else if (pop)   emerg_q <= 1'b0;
  end
`else
  assign flush   = 1'b0;
  assign preempt = 1'b0;
`endif

  assign head = mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          code_d  = head;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (msg_ready) begin
          if (GAP_CYCLES > 0 && !preempt) begin
            state_d = GAP;
            valid_d = 1'b0;
            gap_d   = GW'(GAP_CYCLES);
          end else if (level_q != '0) begin
            pop    = 1'b1;
            code_d = head;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      GAP: begin
        if (preempt && level_q != '0) begin
          pop     = 1'b1;
          code_d  = head;
          valid_d = 1'b1;
          state_d = PRESENT;
        end else if (gap_q <= GW'(1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush rebuilds the queue as a single entry at slot 0; the popped head is not lost.
  always_comb begin
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    wr_d    = wr_q;
    wr_addr = wr_q;
    wr_en   = 1'b0;
    lost    = '0;
    level_d = level_q - (pop ? LW'(1) : LW'(0));
    if (flush) begin
      rd_d    = '0;
      wr_d    = AW'(1);
      wr_addr = '0;
      wr_en   = 1'b1;
      level_d = LW'(1);
      lost    = level_q - (pop ? LW'(1) : LW'(0));
    end else if (accept) begin
      if (level_q != LW'(FIFO_DEPTH) || pop) begin
        wr_en   = 1'b1;
        wr_d    = wr_q + AW'(1);
        level_d = level_d + LW'(1);
      end else begin
        lost = LW'(1);
      end
    end
    drop_sum = {1'b0, drop_q} + 9'(lost);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= gesture_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      drop_q  <= 8'h00;
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= 4'h0;
      gap_q   <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      drop_q  <= drop_d;
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      gap_q   <= gap_d;
    end
  end

  assign msg_valid    = valid_q;
  assign msg_code     = code_q;
  assign accept_pulse = accept_q;
  assign fifo_level   = level_q;
  assign drop_cnt     = drop_q;
  assign busy         = (level_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_gesture_msg_sequencer.sv
// tb/tb_gesture_msg_sequencer.sv - randomized and directed bench for gesture_msg_sequencer
// Emergency scenario is exercised when EMERG_PREEMPT_EN is defined.
module tb_gesture_msg_sequencer;
  localparam int HOLD  = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 8;
`ifdef EMERG_PREEMPT_EN
  localparam bit EMERG = 1'b1;
`else
  localparam bit EMERG = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [3:0]             gesture_in = 4'h0;
  logic                   msg_ready = 1'b0;
  logic                   msg_valid;
  logic [3:0]             msg_code;
  logic                   accept_pulse;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0]             drop_cnt;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  gesture_msg_sequencer #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .gesture_in(gesture_in), .msg_ready(msg_ready),
    .msg_valid(msg_valid), .msg_code(msg_code), .accept_pulse(accept_pulse),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: run length of the input, a queue of accepted codes, and a message slot.
  logic [3:0] m_prev, m_last, m_code;
  logic [3:0] m_q[$];
  int         m_run, m_gap_left, m_drop;
  bit         m_valid, m_acc, m_emerg;

  // Observation of the DUT, gathered as the run proceeds.
  int         cyc, acc_seen, valid_cycles, low_run, min_gap;
  bit         saw_hs, prev_valid;
  logic [3:0] obs_codes[$];
  int         obs_cyc[$];

  task automatic model_reset();
    m_prev = 4'h0; m_last = 4'h0; m_code = 4'h0; m_q.delete();
    m_run = 0; m_gap_left = 0; m_drop = 0; m_valid = 0; m_acc = 0; m_emerg = 0;
  endtask

  task automatic obs_reset();
    cyc = 0; acc_seen = 0; valid_cycles = 0; low_run = 0; min_gap = 1000;
    saw_hs = 0; prev_valid = 0; obs_codes.delete(); obs_cyc.delete();
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_step(input logic [3:0] g, input logic r);
    bit took;
    took = 0;
    m_run = (g == m_prev) ? m_run + 1 : 1;
    m_prev = g;
    m_acc = (m_run == HOLD) && (g != 4'h0) && (g != m_last);
    if (g == 4'h0) m_last = 4'h0;
    else if (m_acc) m_last = g;
    if (m_valid) begin
      if (r) begin
        if (GAP > 0 && !m_emerg) begin m_valid = 0; m_gap_left = GAP; end
        else if (m_q.size() > 0) took = 1;
        else m_valid = 0;
      end
    end else if (m_gap_left > 0) begin
      if (m_emerg && m_q.size() > 0) begin m_gap_left = 0; took = 1; end
      else m_gap_left--;
    end else if (m_q.size() > 0) begin
      took = 1;
    end
    if (took) begin m_code = m_q.pop_front(); m_valid = 1; m_emerg = 0; end
    if (m_acc) begin
      if (EMERG && g == 4'hD) begin
        m_drop = sat255(m_drop + m_q.size());
        m_q.delete();
        m_q.push_back(g);
        m_emerg = 1;
      end else if (m_q.size() < DEPTH) begin
        m_q.push_back(g);
      end else begin
        m_drop = sat255(m_drop + 1);
      end
    end
  endtask

  // Drive one clock cycle: inputs settle, handshake observed before the edge, model stepped at it.
  task automatic tick(input logic [3:0] g, input logic r);
    gesture_in = g;
    msg_ready  = r;
    #1;
    if (msg_valid && msg_ready) begin
      obs_codes.push_back(msg_code);
      obs_cyc.push_back(cyc);
      saw_hs = 1; low_run = 0;
    end
    @(posedge clk);
    model_step(g, r);
    #1;
    cyc++;
    if (accept_pulse) acc_seen++;
    if (msg_valid) begin
      valid_cycles++;
      if (saw_hs && !prev_valid && low_run < min_gap) min_gap = low_run;
    end else begin
      low_run++;
    end
    prev_valid = msg_valid;
  endtask

  task automatic hold(input logic [3:0] g, input logic r, input int n);
    for (int i = 0; i < n; i++) tick(g, r);
  endtask

  task automatic apply_reset();
    gesture_in = 4'h0; msg_ready = 1'b0; rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    obs_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (msg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", msg_valid); end
    if (msg_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h want 0", msg_code); end
    if (accept_pulse !== 1'b0) begin errors++; $display("FAIL reset_accept got %b want 0", accept_pulse); end
    if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    apply_reset();
    hold(4'h0, 1'b1, 3);
    hold(4'h3, 1'b1, HOLD);
    checks += 2;
    if (accept_pulse !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", accept_pulse); end
    if (fifo_level !== 1) begin errors++; $display("FAIL single_level got %0d want 1", fifo_level); end
    tick(4'h3, 1'b1);
    checks += 2;
    if (msg_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", msg_valid); end
    if (msg_code !== 4'h3) begin errors++; $display("FAIL single_code got %h want 3", msg_code); end
    hold(4'h3, 1'b1, 50);
    checks += 3;
    if (acc_seen != 1) begin errors++; $display("FAIL single_accept_count got %0d want 1", acc_seen); end
    if (valid_cycles != 1) begin errors++; $display("FAIL single_valid_cycles got %0d want 1", valid_cycles); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
  endtask

  task automatic test_repeat();
    apply_reset();
    hold(4'h3, 1'b1, 6);
    tick(4'h0, 1'b1);
    hold(4'h3, 1'b1, 30);
    checks += 4;
    if (acc_seen != 2) begin errors++; $display("FAIL repeat_accepts got %0d want 2", acc_seen); end
    if (obs_codes.size() != 2) begin errors++; $display("FAIL repeat_msgs got %0d want 2", obs_codes.size()); end
    else if (obs_codes[0] !== 4'h3 || obs_codes[1] !== 4'h3) begin
      errors++; $display("FAIL repeat_codes got %h %h want 3 3", obs_codes[0], obs_codes[1]);
    end
    if (min_gap < GAP || min_gap >= 1000) begin errors++; $display("FAIL repeat_gap got %0d want >=%0d", min_gap, GAP); end
    if (busy !== 1'b0) begin errors++; $display("FAIL repeat_busy_end got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    logic [3:0] codes[6];
    logic [3:0] want[5];
    bit         code_moved;
    codes = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7};
    want  = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    code_moved = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < HOLD; k++) begin
        tick(codes[i], 1'b0);
        if (i > 0 && msg_code !== 4'h1) code_moved = 1;
      end
    end
    checks += 4;
    if (fifo_level !== 4) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
    if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", drop_cnt); end
    if (msg_valid !== 1'b1 || msg_code !== 4'h1) begin
      errors++; $display("FAIL ovf_present got v=%b c=%h want v=1 c=1", msg_valid, msg_code);
    end
    if (code_moved) begin errors++; $display("FAIL ovf_code_stable got moved want held at 1"); end
    hold(4'h7, 1'b1, 80);
    checks += 2;
    if (obs_codes.size() != 5) begin errors++; $display("FAIL ovf_order_count got %0d want 5", obs_codes.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_codes[i] !== want[i]) begin errors++; $display("FAIL ovf_order[%0d] got %h want %h", i, obs_codes[i], want[i]); end
      end
    end
    if (fifo_level !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_drain got level=%0d busy=%b want 0 0", fifo_level, busy);
    end
  endtask

  task automatic test_glitch();
    logic [3:0] prev, nxt;
    apply_reset();
    prev = 4'h0;
    for (int s = 0; s < 20; s++) begin
      nxt = 4'($urandom_range(1, 15));
      if (nxt == prev) nxt = (prev == 4'hF) ? 4'h1 : prev + 4'h1;
      prev = nxt;
      hold(nxt, 1'b1, HOLD - 1);
    end
    checks += 2;
    if (acc_seen != 0) begin errors++; $display("FAIL glitch_accepts got %0d want 0", acc_seen); end
    if (valid_cycles != 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", valid_cycles); end
  endtask

  task automatic test_drop_saturate();
    apply_reset();
    for (int i = 0; i < 270; i++) hold(4'((i % 12) + 1), 1'b0, HOLD);
    checks += 2;
    if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
    if (fifo_level !== 4) begin errors++; $display("FAIL drop_sat_level got %0d want 4", fifo_level); end
  endtask

  task automatic test_emergency();
    apply_reset();
`ifdef EMERG_PREEMPT_EN
    hold(4'h1, 1'b0, HOLD);
    hold(4'h2, 1'b0, HOLD);
    hold(4'h4, 1'b0, HOLD);
    checks++;
    if (fifo_level !== 2) begin errors++; $display("FAIL emerg_pre_level got %0d want 2", fifo_level); end
    hold(4'hD, 1'b0, HOLD);
    checks += 2;
    if (drop_cnt !== 8'd2) begin errors++; $display("FAIL emerg_drop got %0d want 2", drop_cnt); end
    if (fifo_level !== 1) begin errors++; $display("FAIL emerg_level got %0d want 1", fifo_level); end
    hold(4'hD, 1'b1, 12);
    checks++;
    if (obs_codes.size() != 2) begin errors++; $display("FAIL emerg_msgs got %0d want 2", obs_codes.size()); end
    else begin
      checks += 2;
      if (obs_codes[0] !== 4'h1 || obs_codes[1] !== 4'hD) begin
        errors++; $display("FAIL emerg_order got %h %h want 1 d", obs_codes[0], obs_codes[1]);
      end
      if (obs_cyc[1] - obs_cyc[0] != 1) begin
        errors++; $display("FAIL emerg_no_gap got %0d cycles want 1", obs_cyc[1] - obs_cyc[0]);
      end
    end
`else
    hold(4'h1, 1'b1, HOLD);
    hold(4'hD, 1'b1, 30);
    checks++;
    if (obs_codes.size() != 2) begin errors++; $display("FAIL emergq_msgs got %0d want 2", obs_codes.size()); end
    else begin
      checks += 2;
      if (obs_codes[0] !== 4'h1 || obs_codes[1] !== 4'hD) begin
        errors++; $display("FAIL emergq_order got %h %h want 1 d", obs_codes[0], obs_codes[1]);
      end
      if (min_gap < GAP || min_gap >= 1000) begin errors++; $display("FAIL emergq_gap got %0d want >=%0d", min_gap, GAP); end
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    hold(4'h5, 1'b0, HOLD);
    hold(4'h6, 1'b0, HOLD);
    checks++;
    if (msg_valid !== 1'b1 || fifo_level !== 1) begin
      errors++; $display("FAIL mid_setup got v=%b level=%0d want 1 1", msg_valid, fifo_level);
    end
    #2 rst = 1'b1;
    #1;
    checks += 6;
    if (msg_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", msg_valid); end
    if (msg_code !== 4'h0) begin errors++; $display("FAIL mid_code got %h want 0", msg_code); end
    if (accept_pulse !== 1'b0) begin errors++; $display("FAIL mid_accept got %b want 0", accept_pulse); end
    if (fifo_level !== 0) begin errors++; $display("FAIL mid_level got %0d want 0", fifo_level); end
    if (drop_cnt !== 8'h00) begin errors++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    gesture_in = 4'h0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    obs_reset();
    hold(4'h0, 1'b1, 5);
    checks++;
    if (valid_cycles != 0 || fifo_level !== 0) begin
      errors++; $display("FAIL mid_after got valid_cycles=%0d level=%0d want 0 0", valid_cycles, fifo_level);
    end
  endtask

  task automatic test_random();
    logic [3:0] g;
    int         len;
    bit         slow;
    logic       r;
    apply_reset();
    while (cyc < 3000) begin
      g    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      len  = $urandom_range(1, 10);
      if ($urandom_range(0, 5) == 0) slow = ~slow;
      for (int i = 0; i < len; i++) begin
        r = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
        tick(g, r);
        checks += 6;
        if (msg_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, msg_valid, m_valid); end
        if (msg_code !== m_code) begin errors++; $display("FAIL rnd_code cyc %0d got %h want %h", cyc, msg_code, m_code); end
        if (accept_pulse !== m_acc) begin errors++; $display("FAIL rnd_accept cyc %0d got %b want %b", cyc, accept_pulse, m_acc); end
        if (int'(fifo_level) != m_q.size()) begin errors++; $display("FAIL rnd_level cyc %0d got %0d want %0d", cyc, fifo_level, m_q.size()); end
        if (int'(drop_cnt) != m_drop) begin errors++; $display("FAIL rnd_drop cyc %0d got %0d want %0d", cyc, drop_cnt, m_drop); end
        if (busy !== (m_valid || m_gap_left > 0 || m_q.size() > 0)) begin
          errors++; $display("FAIL rnd_busy cyc %0d got %b", cyc, busy);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    obs_reset();
    test_reset();
    test_single();
    test_repeat();
    test_overflow();
    test_glitch();
    test_drop_saturate();
    test_emergency();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
